// File: rtl/mult_div_pkg.sv
// Shared types and helpers for the iterative multiply/divide sequencer.
package mult_div_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2,
        DONE     = 2'd3
    } md_state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diffLow;

    // The true difference is below the divisor, so W bits hold it exactly.
    always_comb begin
        shifted = {remIn, quoIn[WIDTH-1]};
        diffLow = shifted[WIDTH-1:0] - divisor;
        if (shifted >= {1'b0, divisor}) begin
            remOut = diffLow;
            quoOut = {quoIn[WIDTH-2:0], 1'b1};
        end else begin
            remOut = shifted[WIDTH-1:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring) sequencer writing Hi/Lo.
module mult_div_ctrl
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic                    Op,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    output logic                    Busy,
    output logic                    Done,
    output logic                    DivZero,
    output logic [WIDTH-1:0]        Hi,
    output logic [WIDTH-1:0]        Lo
);

    localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

    md_state_t state, stateNext;
    logic [CNT_W-1:0] count;
    logic             lastIter;
    logic             divZeroFlag;

    logic loadMult, loadDiv, divZeroSet, writeMult, writeDiv;

    logic signed [WIDTH-1:0] mcand;
    logic [2*WIDTH:0]        acc;
    logic [2*WIDTH:0]        accNext;
    logic signed [WIDTH:0]   hiExt, mcandExt, boothSum;

    logic [WIDTH-1:0] divisorMag, remReg, quoReg;
    logic [WIDTH-1:0] remNext, quoNext, remFinal, quoFinal;
    logic             negQuo, negRem;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign lastIter = (count == CNT_W'(WIDTH - 1));
    assign Busy     = (state == MULT_RUN) || (state == DIV_RUN);
    assign Done     = (state == DONE);
    assign DivZero  = Done && divZeroFlag;

    // Booth step: the upper half is widened by one bit so that subtracting the
    // most negative multiplicand cannot overflow before the arithmetic shift.
    always_comb begin
        hiExt    = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        mcandExt = {mcand[WIDTH-1], mcand};
        case (acc[1:0])
            2'b01:   boothSum = hiExt + mcandExt;
            2'b10:   boothSum = hiExt - mcandExt;
            default: boothSum = hiExt;
        endcase
        accNext = {boothSum, acc[WIDTH:1]};
    end

    div_step #(.WIDTH(WIDTH)) uDivStep (
        .remIn   (remReg),
        .quoIn   (quoReg),
        .divisor (divisorMag),
        .remOut  (remNext),
        .quoOut  (quoNext)
    );

    assign quoFinal = negQuo ? -quoNext : quoNext;
    assign remFinal = negRem ? -remNext : remNext;

    always_comb begin
        stateNext  = state;
        loadMult   = 1'b0;
        loadDiv    = 1'b0;
        divZeroSet = 1'b0;
        writeMult  = 1'b0;
        writeDiv   = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (Op == OP_MULT) begin
                        stateNext = MULT_RUN;
                        loadMult  = 1'b1;
                    end else if (B == '0) begin
                        stateNext  = DONE;
                        divZeroSet = 1'b1;
                    end else begin
                        stateNext = DIV_RUN;
                        loadDiv   = 1'b1;
                    end
                end
            end
            MULT_RUN: begin
                if (lastIter) begin
                    stateNext = DONE;
                    writeMult = 1'b1;
                end
            end
            DIV_RUN: begin
                if (lastIter) begin
                    stateNext = DONE;
                    writeDiv  = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            count       <= '0;
            divZeroFlag <= 1'b0;
            Hi          <= '0;
            Lo          <= '0;
        end else begin
            state       <= stateNext;
            divZeroFlag <= divZeroSet;
            if (loadMult || loadDiv) begin
                count <= '0;
            end else if (Busy) begin
                count <= count + 1'b1;
            end
            if (writeMult) begin
                Hi <= accNext[2*WIDTH:WIDTH+1];
                Lo <= accNext[WIDTH:1];
            end else if (writeDiv) begin
                Hi <= remFinal;
                Lo <= quoFinal;
            end
        end
    end

    // Operand and iteration registers; only meaningful while a run is active.
    always_ff @(posedge Clk) begin
        if (loadMult) begin
            mcand <= A;
            acc   <= {{WIDTH{1'b0}}, B, 1'b0};
        end else if (state == MULT_RUN) begin
            acc <= accNext;
        end
        if (loadDiv) begin
            divisorMag <= magnitude(B);
            quoReg     <= magnitude(A);
            remReg     <= '0;
            negQuo     <= A[WIDTH-1] ^ B[WIDTH-1];
            negRem     <= A[WIDTH-1];
        end else if (state == DIV_RUN) begin
            remReg <= remNext;
            quoReg <= quoNext;
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed-vector bench for the multiply/divide sequencer.
module tb_mult_div_ctrl;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               Start;
    logic               Op;
    logic signed [31:0] A;
    logic signed [31:0] B;
    logic               Busy;
    logic               Done;
    logic               DivZero;
    logic [31:0]        Hi;
    logic [31:0]        Lo;

    int nVec  = 0;
    int nMiss = 0;

    mult_div_ctrl #(.WIDTH(32)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .DivZero (DivZero),
        .Hi      (Hi),
        .Lo      (Lo)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        if (obs !== exp) begin
            nMiss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request and returns at the negedge where Done is seen.
    // lat counts cycles from the one following the sampling edge (0 = first).
    task automatic runOp(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input int injectAt, output int lat, output int busyCnt,
                         output int holdErr);
        logic [31:0] preHi, preLo;
        @(negedge Clk);
        preHi = Hi;
        preLo = Lo;
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(negedge Clk);
        Start   = 1'b0;
        lat     = 0;
        busyCnt = 0;
        holdErr = 0;
        while (!Done && lat < 200) begin
            if (Busy) busyCnt++;
            if (Hi !== preHi || Lo !== preLo) holdErr++;
            if (lat == injectAt) begin
                Start = 1'b1;
                Op    = 1'b1;
                A     = 32'd5;
                B     = 32'd0;
            end else begin
                Start = 1'b0;
            end
            @(negedge Clk);
            lat++;
        end
        Start = 1'b0;
    endtask

    int lat, busyCnt, holdErr, doneSeen;

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Op    = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge Clk);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_divzero", 32'(DivZero), 32'd0);
        chk("rst_hi", Hi, 32'h0);
        chk("rst_lo", Lo, 32'h0);
        Reset = 1'b0;

        // 7 * -3 = -21
        runOp(1'b0, 32'd7, 32'hFFFF_FFFD, -1, lat, busyCnt, holdErr);
        chk("t1_lat", 32'(lat), 32'd32);
        chk("t1_busy_cycles", 32'(busyCnt), 32'd32);
        chk("t1_hold", 32'(holdErr), 32'd0);
        chk("t1_hi", Hi, 32'hFFFF_FFFF);
        chk("t1_lo", Lo, 32'hFFFF_FFEB);
        chk("t1_divzero", 32'(DivZero), 32'd0);
        @(negedge Clk);
        chk("t1_done_one_cycle", 32'(Done), 32'd0);

        // (-2^31)^2 = 2^62
        runOp(1'b0, 32'h8000_0000, 32'h8000_0000, -1, lat, busyCnt, holdErr);
        chk("t2_lat", 32'(lat), 32'd32);
        chk("t2_hi", Hi, 32'h4000_0000);
        chk("t2_lo", Lo, 32'h0000_0000);

        // -7 / 2 = -3 rem -1
        runOp(1'b1, 32'hFFFF_FFF9, 32'd2, -1, lat, busyCnt, holdErr);
        chk("t3_lat", 32'(lat), 32'd32);
        chk("t3_hold", 32'(holdErr), 32'd0);
        chk("t3_lo", Lo, 32'hFFFF_FFFD);
        chk("t3_hi", Hi, 32'hFFFF_FFFF);
        chk("t3_divzero", 32'(DivZero), 32'd0);

        // 5 / 0
        runOp(1'b1, 32'd5, 32'd0, -1, lat, busyCnt, holdErr);
        chk("t4_lat", 32'(lat), 32'd0);
        chk("t4_done", 32'(Done), 32'd1);
        chk("t4_divzero", 32'(DivZero), 32'd1);
        chk("t4_hi", Hi, 32'hFFFF_FFFF);
        chk("t4_lo", Lo, 32'hFFFF_FFFD);
        @(negedge Clk);
        chk("t4_done_clear", 32'(Done), 32'd0);
        chk("t4_divzero_clear", 32'(DivZero), 32'd0);

        // -2^31 / -1 wraps
        runOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, busyCnt, holdErr);
        chk("t5_lo", Lo, 32'h8000_0000);
        chk("t5_hi", Hi, 32'h0000_0000);

        // 6 * 7 with a stray divide-by-zero Start in cycle 5
        runOp(1'b0, 32'd6, 32'd7, 5, lat, busyCnt, holdErr);
        chk("t5b_lat", 32'(lat), 32'd32);
        chk("t5b_hold", 32'(holdErr), 32'd0);
        chk("t5b_divzero", 32'(DivZero), 32'd0);
        chk("t5b_hi", Hi, 32'h0);
        chk("t5b_lo", Lo, 32'd42);

        // Abort a divide after 10 cycles
        @(negedge Clk);
        Start = 1'b1;
        Op    = 1'b1;
        A     = 32'd100;
        B     = 32'd7;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        chk("t6_busy_before", 32'(Busy), 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("t6_busy", 32'(Busy), 32'd0);
        chk("t6_done", 32'(Done), 32'd0);
        chk("t6_hi", Hi, 32'h0);
        chk("t6_lo", Lo, 32'h0);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done || Busy) doneSeen++;
            @(negedge Clk);
        end
        chk("t6_no_done", 32'(doneSeen), 32'd0);

        runOp(1'b0, 32'd3, 32'd4, -1, lat, busyCnt, holdErr);
        chk("t6_lat", 32'(lat), 32'd32);
        chk("t6_mult_lo", Lo, 32'd12);
        chk("t6_mult_hi", Hi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
